// File: rtl/udp_tx_segmenter.sv
// udp_tx_segmenter: cuts an application byte stream into UDP-sized datagrams (tlast on source tlast, beat cap or idle timeout).
// Latency: 2 cycles from input accept to m_axis_tvalid; sustains 1 beat/cycle.
// Backpressure: s_axis_tready drops only while the hold and output registers are both full and the output is stalled.
//
// Ports:
//   tx_axis_aclk / tx_axis_aresetn : clock, asynchronous active-low reset
//   s_axis_*                        : application stream in (tlast optional)
//   m_axis_*                        : datagram stream out, fully registered
//   pkt_count                       : datagrams accepted downstream (wraps)
//   flush_count                     : datagrams closed by idle timeout (wraps)
module udp_tx_segmenter #(
  parameter int DATA_WIDTH   = 512,
  parameter int KEEP_WIDTH   = DATA_WIDTH/8,
  parameter int MAX_BEATS    = 22,
  parameter int IDLE_TIMEOUT = 256,
  parameter int CNT_WIDTH    = 32
) (
  input  logic                  tx_axis_aclk,
  input  logic                  tx_axis_aresetn,
  input  logic [DATA_WIDTH-1:0] s_axis_tdata,
  input  logic [KEEP_WIDTH-1:0] s_axis_tkeep,
  input  logic                  s_axis_tvalid,
  input  logic                  s_axis_tlast,
  output logic                  s_axis_tready,
  output logic [DATA_WIDTH-1:0] m_axis_tdata,
  output logic [KEEP_WIDTH-1:0] m_axis_tkeep,
  output logic                  m_axis_tvalid,
  output logic                  m_axis_tlast,
  input  logic                  m_axis_tready,
  output logic [CNT_WIDTH-1:0]  pkt_count,
  output logic [CNT_WIDTH-1:0]  flush_count
);

  localparam int              IDLE_W   = (IDLE_TIMEOUT > 0) ? $clog2(IDLE_TIMEOUT + 1) : 1;
  localparam logic [IDLE_W-1:0] IDLE_MAX = IDLE_W'(IDLE_TIMEOUT);
  localparam logic [7:0]      CAP_VAL  = 8'(MAX_BEATS - 1);
  localparam bit              TMO_EN   = (IDLE_TIMEOUT != 0);

  // Hold register: keeps the newest beat until we know whether it ends a datagram.
  logic [DATA_WIDTH-1:0] h_dat;
  logic [KEEP_WIDTH-1:0] h_keep;
  logic                  h_last;
  logic                  h_vld;

  logic [7:0]        beat_cnt;
  logic [IDLE_W-1:0] idle_cnt;

  logic o_free, cap, tmo, move, close, accept;

  assign o_free = !m_axis_tvalid | m_axis_tready;
  assign cap    = (beat_cnt == CAP_VAL);
  assign tmo    = TMO_EN & (idle_cnt == IDLE_MAX);
  // The held beat may only leave once its tlast is known: a follower arrived,
  // or it closes the datagram anyway (source tlast, cap, timeout).
  assign move   = h_vld & o_free & (h_last | cap | s_axis_tvalid | tmo);
  assign close  = h_last | cap | tmo;
  assign s_axis_tready = !h_vld | move;
  assign accept = s_axis_tvalid & s_axis_tready;

  always_ff @(posedge tx_axis_aclk or negedge tx_axis_aresetn) begin
    if (!tx_axis_aresetn) begin
      h_dat  <= '0;
      h_keep <= '0;
      h_last <= 1'b0;
      h_vld  <= 1'b0;
    end else if (accept) begin
      h_dat  <= s_axis_tdata;
      h_keep <= s_axis_tkeep;
      h_last <= s_axis_tlast;
      h_vld  <= 1'b1;
    end else if (move) begin
      h_vld  <= 1'b0;
    end
  end

  always_ff @(posedge tx_axis_aclk or negedge tx_axis_aresetn) begin
    if (!tx_axis_aresetn) begin
      m_axis_tdata  <= '0;
      m_axis_tkeep  <= '0;
      m_axis_tlast  <= 1'b0;
      m_axis_tvalid <= 1'b0;
    end else if (move) begin
      m_axis_tdata  <= h_dat;
      m_axis_tkeep  <= h_keep;
      m_axis_tlast  <= close;
      m_axis_tvalid <= 1'b1;
    end else if (m_axis_tready) begin
      m_axis_tvalid <= 1'b0;
    end
  end

  always_ff @(posedge tx_axis_aclk or negedge tx_axis_aresetn) begin
    if (!tx_axis_aresetn) begin
      beat_cnt <= '0;
    end else if (move) begin
      beat_cnt <= close ? 8'd0 : beat_cnt + 8'd1;
    end
  end

  // Counts idle cycles of a held beat; with IDLE_TIMEOUT=0 IDLE_MAX is 0 so it never moves.
  always_ff @(posedge tx_axis_aclk or negedge tx_axis_aresetn) begin
    if (!tx_axis_aresetn) begin
      idle_cnt <= '0;
    end else if (accept || move) begin
      idle_cnt <= '0;
    end else if (h_vld && !s_axis_tvalid && (idle_cnt != IDLE_MAX)) begin
      idle_cnt <= idle_cnt + 1'b1;
    end
  end

  always_ff @(posedge tx_axis_aclk or negedge tx_axis_aresetn) begin
    if (!tx_axis_aresetn) begin
      pkt_count   <= '0;
      flush_count <= '0;
    end else begin
      if (m_axis_tvalid && m_axis_tready && m_axis_tlast)
        pkt_count <= pkt_count + 1'b1;
      if (move && tmo && !h_last && !cap)
        flush_count <= flush_count + 1'b1;
    end
  end

endmodule

// File: tb/tb_udp_tx_segmenter.sv
module tb_udp_tx_segmenter;

  localparam int DW = 512;
  localparam int KW = 64;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;

  logic [DW-1:0] s_dat;  logic [KW-1:0] s_keep; logic s_vld, s_last, s_rdy;
  logic [DW-1:0] m_dat;  logic [KW-1:0] m_keep; logic m_vld, m_last, m_rdy;
  logic [31:0]   pkt, flush;

  logic [DW-1:0] zs_dat; logic [KW-1:0] zs_keep; logic zs_vld, zs_last, zs_rdy;
  logic [DW-1:0] zm_dat; logic [KW-1:0] zm_keep; logic zm_vld, zm_last, zm_rdy;
  logic [31:0]   z_pkt, z_flush;

  udp_tx_segmenter #(.DATA_WIDTH(DW), .KEEP_WIDTH(KW), .MAX_BEATS(22), .IDLE_TIMEOUT(16), .CNT_WIDTH(32)) dut (
    .tx_axis_aclk(clk), .tx_axis_aresetn(rst_n),
    .s_axis_tdata(s_dat), .s_axis_tkeep(s_keep), .s_axis_tvalid(s_vld), .s_axis_tlast(s_last), .s_axis_tready(s_rdy),
    .m_axis_tdata(m_dat), .m_axis_tkeep(m_keep), .m_axis_tvalid(m_vld), .m_axis_tlast(m_last), .m_axis_tready(m_rdy),
    .pkt_count(pkt), .flush_count(flush)
  );

  udp_tx_segmenter #(.DATA_WIDTH(DW), .KEEP_WIDTH(KW), .MAX_BEATS(22), .IDLE_TIMEOUT(0), .CNT_WIDTH(32)) dut_z (
    .tx_axis_aclk(clk), .tx_axis_aresetn(rst_n),
    .s_axis_tdata(zs_dat), .s_axis_tkeep(zs_keep), .s_axis_tvalid(zs_vld), .s_axis_tlast(zs_last), .s_axis_tready(zs_rdy),
    .m_axis_tdata(zm_dat), .m_axis_tkeep(zm_keep), .m_axis_tvalid(zm_vld), .m_axis_tlast(zm_last), .m_axis_tready(zm_rdy),
    .pkt_count(z_pkt), .flush_count(z_flush)
  );

  typedef struct {
    logic [DW-1:0] dat;
    logic [KW-1:0] keep;
    logic          last;
    int            cyc;
  } beat_t;

  beat_t out_q[$];
  beat_t z_q[$];
  int    in_cyc[$];
  int    stall_cycles;
  int    cyc;
  int    checks = 0;
  int    errors = 0;
  beat_t mon_b, mon_z;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (rst_n) begin
      if (m_vld && m_rdy) begin
        mon_b.dat = m_dat; mon_b.keep = m_keep; mon_b.last = m_last; mon_b.cyc = cyc;
        out_q.push_back(mon_b);
      end
      if (s_vld && s_rdy) in_cyc.push_back(cyc);
      if (s_vld && !s_rdy) stall_cycles++;
      if (zm_vld && zm_rdy) begin
        mon_z.dat = zm_dat; mon_z.keep = zm_keep; mon_z.last = zm_last; mon_z.cyc = cyc;
        z_q.push_back(mon_z);
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic do_reset();
    s_vld = 1'b0; s_last = 1'b0; s_dat = '0; s_keep = '0; m_rdy = 1'b1;
    zs_vld = 1'b0; zs_last = 1'b0; zs_dat = '0; zs_keep = '0; zm_rdy = 1'b1;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    out_q.delete(); z_q.delete(); in_cyc.delete(); stall_cycles = 0;
  endtask

  // Presents one beat and returns 1 ns after the edge on which it was accepted.
  task automatic send(input logic [31:0] v, input logic [KW-1:0] k, input logic l);
    logic ok;
    s_dat = {16{v}}; s_keep = k; s_last = l; s_vld = 1'b1;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      ok = s_rdy;
      @(posedge clk);
      #1;
      if (ok) return;
    end
    errors++;
    $display("FAIL send_timeout: beat %h not accepted within 200 cycles", v);
  endtask

  task automatic wait_out(input int n, input string name);
    int i = 0;
    while (out_q.size() < n && i < 400) begin
      @(posedge clk);
      i++;
    end
    repeat (4) @(posedge clk);
    #1;
    checks++;
    if (out_q.size() != n) begin
      errors++;
      $display("FAIL %s_count: got %0d beats, expected %0d", name, out_q.size(), n);
    end
  endtask

  task automatic test_reset();
    s_vld = 1'b0; s_last = 1'b0; s_dat = '0; s_keep = '0; m_rdy = 1'b1;
    zs_vld = 1'b0; zs_last = 1'b0; zs_dat = '0; zs_keep = '0; zm_rdy = 1'b1;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    checks++; if (m_vld !== 1'b0)  begin errors++; $display("FAIL reset_tvalid: got %b expected 0", m_vld); end
    checks++; if (m_last !== 1'b0) begin errors++; $display("FAIL reset_tlast: got %b expected 0", m_last); end
    checks++; if (m_dat !== '0)    begin errors++; $display("FAIL reset_tdata: got %h expected 0", m_dat[31:0]); end
    checks++; if (m_keep !== '0)   begin errors++; $display("FAIL reset_tkeep: got %h expected 0", m_keep); end
    checks++; if (pkt !== 32'd0)   begin errors++; $display("FAIL reset_pkt: got %0d expected 0", pkt); end
    checks++; if (flush !== 32'd0) begin errors++; $display("FAIL reset_flush: got %0d expected 0", flush); end
    checks++; if (s_rdy !== 1'b1)  begin errors++; $display("FAIL reset_tready: got %b expected 1", s_rdy); end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic test_basic();
    logic [31:0]   ev[3];
    logic [KW-1:0] ek[3];
    logic          el[3];
    ev = '{32'h1111_0001, 32'h2222_0002, 32'h3333_0003};
    ek = '{{KW{1'b1}}, {KW{1'b0}}, 64'h0000_0000_0000_000F};
    el = '{1'b0, 1'b0, 1'b1};
    do_reset();
    for (int i = 0; i < 3; i++) send(ev[i], ek[i], el[i]);
    s_vld = 1'b0;
    wait_out(3, "basic");
    for (int i = 0; i < 3 && i < out_q.size(); i++) begin
      checks++; if (out_q[i].dat !== {16{ev[i]}}) begin errors++; $display("FAIL basic_data[%0d]: got %h expected %h", i, out_q[i].dat[31:0], ev[i]); end
      checks++; if (out_q[i].keep !== ek[i])      begin errors++; $display("FAIL basic_keep[%0d]: got %h expected %h", i, out_q[i].keep, ek[i]); end
      checks++; if (out_q[i].last !== el[i])      begin errors++; $display("FAIL basic_last[%0d]: got %b expected %b", i, out_q[i].last, el[i]); end
      if (out_q.size() > 0 && in_cyc.size() > 0) begin
        checks++;
        if (out_q[i].cyc - in_cyc[0] != 2 + i) begin
          errors++; $display("FAIL basic_timing[%0d]: got %0d cycles after first accept, expected %0d", i, out_q[i].cyc - in_cyc[0], 2 + i);
        end
      end
    end
    checks++; if (pkt !== 32'd1)   begin errors++; $display("FAIL basic_pkt: got %0d expected 1", pkt); end
    checks++; if (flush !== 32'd0) begin errors++; $display("FAIL basic_flush: got %0d expected 0", flush); end
  endtask

  task automatic test_cap();
    logic el;
    do_reset();
    for (int i = 0; i < 50; i++) send(32'h100 + i, {KW{1'b1}}, i == 49);
    s_vld = 1'b0;
    wait_out(50, "cap");
    for (int i = 0; i < 50 && i < out_q.size(); i++) begin
      el = (i == 21) || (i == 43) || (i == 49);
      checks++; if (out_q[i].dat !== {16{32'h100 + i}}) begin errors++; $display("FAIL cap_data[%0d]: got %h expected %h", i, out_q[i].dat[31:0], 32'h100 + i); end
      checks++; if (out_q[i].last !== el)              begin errors++; $display("FAIL cap_last[%0d]: got %b expected %b", i, out_q[i].last, el); end
      checks++; if (out_q[i].cyc != out_q[0].cyc + i)  begin errors++; $display("FAIL cap_bubble[%0d]: got cycle offset %0d expected %0d", i, out_q[i].cyc - out_q[0].cyc, i); end
    end
    checks++; if (stall_cycles != 0) begin errors++; $display("FAIL cap_input_stall: got %0d stall cycles expected 0", stall_cycles); end
    checks++; if (pkt !== 32'd3)     begin errors++; $display("FAIL cap_pkt: got %0d expected 3", pkt); end
    checks++; if (flush !== 32'd0)   begin errors++; $display("FAIL cap_flush: got %0d expected 0", flush); end
  endtask

  task automatic test_idle_flush();
    do_reset();
    for (int i = 0; i < 5; i++) send(32'h200 + i, {KW{1'b1}}, 1'b0);
    s_vld = 1'b0;
    wait_out(5, "idle");
    for (int i = 0; i < 5 && i < out_q.size(); i++) begin
      checks++; if (out_q[i].dat !== {16{32'h200 + i}}) begin errors++; $display("FAIL idle_data[%0d]: got %h expected %h", i, out_q[i].dat[31:0], 32'h200 + i); end
      checks++; if (out_q[i].last !== (i == 4))         begin errors++; $display("FAIL idle_last[%0d]: got %b expected %b", i, out_q[i].last, i == 4); end
    end
    // Held beat: idle_cnt counts 0..16 over 17 cycles, then one cycle into O.
    if (out_q.size() == 5 && in_cyc.size() == 5) begin
      checks++;
      if (out_q[4].cyc - in_cyc[4] != 18) begin
        errors++; $display("FAIL idle_flush_delay: got %0d cycles expected 18", out_q[4].cyc - in_cyc[4]);
      end
    end
    checks++; if (flush !== 32'd1) begin errors++; $display("FAIL idle_flush_count: got %0d expected 1", flush); end
    checks++; if (pkt !== 32'd1)   begin errors++; $display("FAIL idle_pkt: got %0d expected 1", pkt); end
  endtask

  task automatic test_tmo_precedence();
    do_reset();
    send(32'h300, {KW{1'b1}}, 1'b0);
    s_vld = 1'b0;
    // Land the next beat exactly on the cycle idle_cnt hits 16.
    repeat (16) @(posedge clk);
    #1;
    send(32'h301, {KW{1'b1}}, 1'b1);
    s_vld = 1'b0;
    wait_out(2, "tmo_prec");
    if (out_q.size() == 2) begin
      checks++; if (out_q[0].dat !== {16{32'h300}}) begin errors++; $display("FAIL tmo_prec_data0: got %h expected 300", out_q[0].dat[31:0]); end
      checks++; if (out_q[0].last !== 1'b1)         begin errors++; $display("FAIL tmo_prec_last0: got %b expected 1", out_q[0].last); end
      checks++; if (out_q[1].dat !== {16{32'h301}}) begin errors++; $display("FAIL tmo_prec_data1: got %h expected 301", out_q[1].dat[31:0]); end
      checks++; if (out_q[1].last !== 1'b1)         begin errors++; $display("FAIL tmo_prec_last1: got %b expected 1", out_q[1].last); end
    end
    checks++; if (flush !== 32'd1) begin errors++; $display("FAIL tmo_prec_flush: got %0d expected 1", flush); end
    checks++; if (pkt !== 32'd2)   begin errors++; $display("FAIL tmo_prec_pkt: got %0d expected 2", pkt); end
  endtask

  task automatic test_backpressure();
    do_reset();
    fork
      begin
        m_rdy = 1'b1;
        for (int t = 0; t < 60; t++) begin
          @(posedge clk);
          #1;
          m_rdy = ~m_rdy;
        end
        m_rdy = 1'b1;
      end
      begin
        for (int i = 0; i < 12; i++) send(32'h400 + i, {KW{1'b1}}, i == 11);
        s_vld = 1'b0;
      end
    join
    wait_out(12, "bp");
    for (int i = 0; i < 12 && i < out_q.size(); i++) begin
      checks++; if (out_q[i].dat !== {16{32'h400 + i}}) begin errors++; $display("FAIL bp_data[%0d]: got %h expected %h", i, out_q[i].dat[31:0], 32'h400 + i); end
      checks++; if (out_q[i].last !== (i == 11))        begin errors++; $display("FAIL bp_last[%0d]: got %b expected %b", i, out_q[i].last, i == 11); end
      if (i > 0) begin
        checks++;
        if (out_q[i].cyc - out_q[i-1].cyc != 2) begin
          errors++; $display("FAIL bp_rate[%0d]: got spacing %0d expected 2", i, out_q[i].cyc - out_q[i-1].cyc);
        end
      end
    end
    checks++; if (stall_cycles == 0) begin errors++; $display("FAIL bp_tready_drop: got 0 stall cycles expected nonzero"); end
    checks++; if (pkt !== 32'd1)     begin errors++; $display("FAIL bp_pkt: got %0d expected 1", pkt); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    send(32'h490, {KW{1'b1}}, 1'b0);
    send(32'h491, {KW{1'b1}}, 1'b1);
    for (int i = 0; i < 10; i++) send(32'h500 + i, {KW{1'b1}}, 1'b0);
    s_vld = 1'b0;
    checks++; if (pkt !== 32'd1) begin errors++; $display("FAIL rmid_pkt_before: got %0d expected 1", pkt); end
    rst_n = 1'b0;
    @(negedge clk);
    checks++; if (m_vld !== 1'b0)  begin errors++; $display("FAIL rmid_tvalid_in_reset: got %b expected 0", m_vld); end
    checks++; if (pkt !== 32'd0)   begin errors++; $display("FAIL rmid_pkt_in_reset: got %0d expected 0", pkt); end
    checks++; if (s_rdy !== 1'b1)  begin errors++; $display("FAIL rmid_tready_in_reset: got %b expected 1", s_rdy); end
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    out_q.delete(); in_cyc.delete();
    send(32'h600, {KW{1'b1}}, 1'b0);
    send(32'h601, {KW{1'b1}}, 1'b1);
    s_vld = 1'b0;
    wait_out(2, "rmid");
    if (out_q.size() == 2) begin
      checks++; if (out_q[0].dat !== {16{32'h600}}) begin errors++; $display("FAIL rmid_data0: got %h expected 600", out_q[0].dat[31:0]); end
      checks++; if (out_q[0].last !== 1'b0)         begin errors++; $display("FAIL rmid_last0: got %b expected 0", out_q[0].last); end
      checks++; if (out_q[1].dat !== {16{32'h601}}) begin errors++; $display("FAIL rmid_data1: got %h expected 601", out_q[1].dat[31:0]); end
      checks++; if (out_q[1].last !== 1'b1)         begin errors++; $display("FAIL rmid_last1: got %b expected 1", out_q[1].last); end
    end
    checks++; if (pkt !== 32'd1)   begin errors++; $display("FAIL rmid_pkt_after: got %0d expected 1", pkt); end
    checks++; if (flush !== 32'd0) begin errors++; $display("FAIL rmid_flush_after: got %0d expected 0", flush); end
  endtask

  task automatic test_idle_zero();
    do_reset();
    zs_dat = {16{32'h700}}; zs_keep = {KW{1'b1}}; zs_last = 1'b0; zs_vld = 1'b1;
    @(negedge clk);
    checks++; if (zs_rdy !== 1'b1) begin errors++; $display("FAIL zero_accept0: got tready %b expected 1", zs_rdy); end
    @(posedge clk);
    #1;
    zs_vld = 1'b0;
    repeat (1000) @(posedge clk);
    @(negedge clk);
    checks++; if (zm_vld !== 1'b0)   begin errors++; $display("FAIL zero_held_tvalid: got %b expected 0", zm_vld); end
    checks++; if (z_flush !== 32'd0) begin errors++; $display("FAIL zero_held_flush: got %0d expected 0", z_flush); end
    checks++; if (z_q.size() != 0)   begin errors++; $display("FAIL zero_held_beats: got %0d beats expected 0", z_q.size()); end
    @(posedge clk);
    #1;
    zs_dat = {16{32'h701}}; zs_last = 1'b1; zs_vld = 1'b1;
    @(negedge clk);
    checks++; if (zs_rdy !== 1'b1) begin errors++; $display("FAIL zero_accept1: got tready %b expected 1", zs_rdy); end
    @(posedge clk);
    #1;
    zs_vld = 1'b0; zs_last = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    checks++; if (z_q.size() != 2) begin errors++; $display("FAIL zero_release_count: got %0d beats expected 2", z_q.size()); end
    if (z_q.size() == 2) begin
      checks++; if (z_q[0].dat !== {16{32'h700}}) begin errors++; $display("FAIL zero_data0: got %h expected 700", z_q[0].dat[31:0]); end
      checks++; if (z_q[0].last !== 1'b0)         begin errors++; $display("FAIL zero_last0: got %b expected 0", z_q[0].last); end
      checks++; if (z_q[1].dat !== {16{32'h701}}) begin errors++; $display("FAIL zero_data1: got %h expected 701", z_q[1].dat[31:0]); end
      checks++; if (z_q[1].last !== 1'b1)         begin errors++; $display("FAIL zero_last1: got %b expected 1", z_q[1].last); end
    end
    checks++; if (z_pkt !== 32'd1)   begin errors++; $display("FAIL zero_pkt: got %0d expected 1", z_pkt); end
    checks++; if (z_flush !== 32'd0) begin errors++; $display("FAIL zero_flush: got %0d expected 0", z_flush); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_cap();
    test_idle_flush();
    test_tmo_precedence();
    test_backpressure();
    test_reset_mid();
    test_idle_zero();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
